ncc_pe: RTL and testbench
=========================

Name: ncc_pe

Overview:
- 16-lane log-domain multiply-accumulate processing element for normalized cross-correlation (NCC) template matching in the vision pipeline.
- Per lane, takes a descriptor pixel and a window pixel, both already converted to log2 form upstream.
- Registers the window operands, forms each product by log addition plus a Mitchell antilog, and accumulates into saturating 8-bit per-lane sums.

Parameters:
- NUM_LANES, 16, number of parallel pixel lanes.
- INT_W, 5, integer bits of the log2 magnitude.
- FRAC_W, 27, fractional bits of the log2 magnitude.
- ACC_W, 8, width of each lane accumulator/output.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_acc_sum_reg  in  1  accumulate enable: add the current lane products into the accumulators.
- load_win_reg  in  1  window load enable: capture win_log into the window register bank.
- desc_log  in  NUM_LANES x (1+INT_W+FRAC_W)  per-lane descriptor operand; bit[INT_W] = zero flag, bits[INT_W-1:-FRAC_W] = unsigned Q5.27 log2 magnitude.
- win_log  in  NUM_LANES x (1+INT_W+FRAC_W)  per-lane window operand, same format as desc_log.
- acc_out  out  NUM_LANES x ACC_W  registered per-lane accumulator values.

Behaviour:
- Operand format:
  - Zero flag = 1 means the pixel is 0; the magnitude bits are then ignored.
  - Otherwise the magnitude is the Mitchell log2 of the pixel: n = MSB index, f = remaining bits below the MSB, left-aligned into the fraction.
  - Example encodings: 3 -> 1.5, 5 -> 2.25.
- Reset (rst=1 at a clock edge):
  - All acc_out lanes -> 0.
  - All window registers -> zero flag 1, magnitude 0.
  - Reset has priority over both load enables.
- Window load:
  - load_win_reg=1 at an edge -> win_reg[i] <= win_log[i] for all lanes.
  - Otherwise win_reg holds its value.
- Product, combinational, per lane:
  - If desc zero flag or win_reg zero flag is set, the product is 0.
  - Otherwise S = desc_mag + win_mag, an unsigned Q6.27 value; n = int(S), f = frac(S).
  - Product = floor((1+f) * 2^n) (Mitchell antilog).
  - n >= ACC_W saturates the product to 2^ACC_W - 1 = 255.
- Accumulate:
  - load_acc_sum_reg=1 at an edge -> acc[i] <= min(acc[i] + product[i], 255).
  - Otherwise acc holds its value.
- Simultaneous load_win_reg and load_acc_sum_reg: the accumulate uses the pre-edge (old) win_reg; the new window takes effect from the next cycle.
- Latency: acc_out reflects an accumulate one cycle after the enabling edge, i.e. it is a registered output with no further pipeline.
- desc_log is used combinationally at the accumulate edge and is not registered.
- Accumulators never wrap; they stick at 255 until reset.

Optional Feature:
- Macro: NCC_PE_OVF_FLAG_EN.
- With the macro defined:
  - Adds output port acc_ovf (NUM_LANES bits).
  - Bit i is a sticky flag, set when any saturation occurs in lane i, either at product level or at accumulator level.
  - Cleared only by rst.
- Without the macro: the port is absent and saturation is silent.

Decomposition:
- Package ncc_pkg holds:
  - Constants NUM_LANES, INT_W, FRAC_W, ACC_W.
  - Typedefs log_t (packed, 1+INT_W+FRAC_W bits: zero flag + magnitude) and acc_t.
  - A function mitchell_log2(8-bit pixel) -> log_t, for use by upstream converters and the bench.
- One natural sub-module, ncc_antilog_lane: operand add, zero gating and Mitchell antilog with saturation. It is instantiated NUM_LANES times; accumulators and window registers stay in ncc_pe.

Test Plan:
1. Reset, then pulse load_acc_sum_reg with any desc_log and no window load -> every acc_out lane = 0 (window zero flags set by reset).
2. Setup:
   - desc pixel i = i and window pixel i = i+1 for lanes 0..14, lane 15 both 0.
   - Pulse load_win_reg, then pulse load_acc_sum_reg on the next cycle.
   - Expected acc_out: lane0=0, lane1=2, lane3=12, lane4=20, lane14=208, lane15=0.
3. Repeat the accumulate pulse from scenario 2 once more with unchanged inputs -> lane1=4, lane3=24, lane4=40, lane14=255 (saturated).
4. All lanes desc=255 and window=255; load the window, then accumulate -> every lane = 255. A further accumulate keeps 255, and acc_ovf is all ones when the macro is defined.
5. Window bank holds 4 in all lanes; desc = 3 in all lanes; assert load_win_reg (window 8) and load_acc_sum_reg in the same cycle:
   - First accumulate adds 12 per lane (old window 4).
   - Next accumulate adds 24 per lane (window 8), total 36.
6. With accumulators non-zero, assert rst together with both load enables -> acc_out = 0 next cycle and the window zero flags are set.

Source files
------------

// File: rtl/ncc_pkg.sv
// -----------------------------------------------------------------------------
// ncc_pkg
// Shared constants, operand/accumulator types and the Mitchell log2 helper for
// the NCC log-domain processing element. Upstream pixel converters and the
// bench call mitchell_log2() so that every producer agrees on one operand format.
//
// Operand format (log_t, 1+INT_W+FRAC_W bits):
//   zero : 1 = the pixel is 0 (the magnitude bits are then ignored)
//   mag  : unsigned Q5.27 Mitchell log2 -> {MSB index, bits below MSB left-aligned}
// -----------------------------------------------------------------------------
package ncc_pkg;

    localparam int unsigned NUM_LANES = 16;
    localparam int unsigned INT_W     = 5;
    localparam int unsigned FRAC_W    = 27;
    localparam int unsigned ACC_W     = 8;

    // Derived widths
    localparam int unsigned MAG_W     = INT_W + FRAC_W;       // Q5.27 magnitude
    localparam int unsigned SUM_W     = MAG_W + 1;            // Q6.27 sum of two magnitudes
    localparam int unsigned LOG_W     = 1 + MAG_W;            // zero flag + magnitude
    localparam int unsigned PIX_W     = 8;                    // raw pixel width
    localparam int unsigned PIX_IDX_W = $clog2(PIX_W);        // MSB index of a pixel
    localparam int unsigned EXT_W     = FRAC_W + PIX_W;       // pixel aligned under the binary point

    typedef struct packed {
        logic             zero;
        logic [MAG_W-1:0] mag;
    } log_t;

    typedef logic [ACC_W-1:0] acc_t;

    localparam acc_t ACC_MAX   = '1;
    localparam log_t LOG_ZERO  = '{zero: 1'b1, mag: '0};

    // Mitchell log2 of an 8-bit pixel: integer part = MSB index, fraction =
    // the bits below the MSB shifted up so they sit directly under the point.
    function automatic log_t mitchell_log2(input logic [PIX_W-1:0] pix);
        log_t                 res;
        logic [PIX_IDX_W-1:0] msb;
        logic [EXT_W-1:0]     ext;
        res = LOG_ZERO;
        msb = '0;
        ext = '0;
        for (int i = 0; i < PIX_W; i++) begin
            if (pix[i]) msb = PIX_IDX_W'(i);
        end
        if (pix != '0) begin
            // Place the MSB at bit FRAC_W; the fraction is everything below it.
            ext       = EXT_W'(pix) << (FRAC_W - 32'(msb));
            res.zero  = 1'b0;
            res.mag   = {INT_W'(msb), FRAC_W'(ext)};
        end
        return res;
    endfunction

endpackage

// File: rtl/ncc_pe_if.sv
// -----------------------------------------------------------------------------
// ncc_pe_if
// Bundles the NCC processing element's load strobes, per-lane operands and
// accumulator outputs.
//   load_acc_sum_reg : accumulate enable
//   load_win_reg     : window register bank load enable
//   desc_log         : per-lane descriptor operand (log_t)
//   win_log          : per-lane window operand (log_t)
//   acc_out          : per-lane registered accumulator value
//   acc_ovf          : per-lane sticky saturation flag (only with NCC_PE_OVF_FLAG_EN)
// Modports: master drives operands/strobes, slave is the processing element.
// -----------------------------------------------------------------------------
interface ncc_pe_if;
    import ncc_pkg::*;

    logic                  load_acc_sum_reg;
    logic                  load_win_reg;
    log_t [NUM_LANES-1:0]  desc_log;
    log_t [NUM_LANES-1:0]  win_log;
    acc_t [NUM_LANES-1:0]  acc_out;
`ifdef NCC_PE_OVF_FLAG_EN
    logic [NUM_LANES-1:0]  acc_ovf;

    modport master (
        output load_acc_sum_reg, load_win_reg, desc_log, win_log,
        input  acc_out, acc_ovf
    );

    modport slave (
        input  load_acc_sum_reg, load_win_reg, desc_log, win_log,
        output acc_out, acc_ovf
    );
`else
    modport master (
        output load_acc_sum_reg, load_win_reg, desc_log, win_log,
        input  acc_out
    );

    modport slave (
        input  load_acc_sum_reg, load_win_reg, desc_log, win_log,
        output acc_out
    );
`endif

endinterface

// File: rtl/ncc_antilog_lane.sv
// -----------------------------------------------------------------------------
// ncc_antilog_lane
// One lane of the log-domain multiplier: adds the two log2 magnitudes, gates
// the result to zero when either operand is a zero pixel, and converts back to
// the linear domain with the Mitchell antilog floor((1+f) * 2^n). Products that
// need n >= ACC_W do not fit the accumulator width and saturate to ACC_MAX.
//   desc      : descriptor operand (log_t)
//   win       : registered window operand (log_t)
//   product_c : combinational linear-domain product
//   sat_c     : combinational product-saturation indicator
// -----------------------------------------------------------------------------
module ncc_antilog_lane
    import ncc_pkg::*;
(
    input  log_t desc,
    input  log_t win,
    output acc_t product_c,
    output logic sat_c
);

    localparam int unsigned N_W     = SUM_W - FRAC_W;     // integer bits of the sum
    localparam int unsigned SHAMT_W = $clog2(ACC_W);      // shifts that still fit ACC_W
    localparam int unsigned SH_W    = FRAC_W + ACC_W;     // mantissa after the largest legal shift

    logic [SUM_W-1:0]  sum;
    logic [N_W-1:0]    n;
    logic [FRAC_W-1:0] f;
    logic [SH_W-1:0]   shifted;

    // Log add + Mitchell antilog with zero gating and saturation
    always_comb begin
        sum       = SUM_W'(desc.mag) + SUM_W'(win.mag);
        n         = sum[SUM_W-1:FRAC_W];
        f         = sum[FRAC_W-1:0];
        // 1.f scaled by 2^n; the integer part is what remains above the point.
        shifted   = SH_W'({1'b1, f}) << n[SHAMT_W-1:0];
        product_c = '0;
        sat_c     = 1'b0;
        if (!(desc.zero || win.zero)) begin
            if (n >= N_W'(ACC_W)) begin
                product_c = ACC_MAX;
                sat_c     = 1'b1;
            end else begin
                product_c = ACC_W'(shifted >> FRAC_W);
            end
        end
    end

endmodule

// File: rtl/ncc_pe.sv
// -----------------------------------------------------------------------------
// ncc_pe
// 16-lane log-domain multiply-accumulate processing element for NCC template
// matching. Each lane multiplies its descriptor operand by a registered window
// operand (log add + Mitchell antilog) and accumulates into a saturating
// ACC_W-bit sum that sticks at ACC_MAX until reset.
//   clk  : system clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, priority over both load strobes
//   bus  : ncc_pe_if.slave (strobes, desc_log, win_log, acc_out[, acc_ovf])
// Optional build macro NCC_PE_OVF_FLAG_EN adds acc_ovf, a per-lane sticky flag
// set whenever an accumulate saturates (at product or accumulator level).
// -----------------------------------------------------------------------------
module ncc_pe
    import ncc_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    ncc_pe_if.slave  bus
);

    log_t           win_reg    [NUM_LANES];
    acc_t           acc_reg    [NUM_LANES];
    acc_t           product_c  [NUM_LANES];
    logic           prod_sat_c [NUM_LANES];
    logic [ACC_W:0] sum_c      [NUM_LANES];
    logic           clamp_c    [NUM_LANES];
    acc_t           acc_next_c [NUM_LANES];

    // Per-lane multiplier and saturating accumulate arithmetic
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        ncc_antilog_lane u_antilog (
            .desc      (bus.desc_log[g]),
            .win       (win_reg[g]),
            .product_c (product_c[g]),
            .sat_c     (prod_sat_c[g])
        );

        // A saturated product is already ACC_MAX, so the clamped result is
        // ACC_MAX whether the overflow came from the product or the carry.
        assign sum_c[g]      = {1'b0, acc_reg[g]} + {1'b0, product_c[g]};
        assign clamp_c[g]    = prod_sat_c[g] | sum_c[g][ACC_W];
        assign acc_next_c[g] = clamp_c[g] ? ACC_MAX : sum_c[g][ACC_W-1:0];

        assign bus.acc_out[g] = acc_reg[g];
    end

    // Window bank and accumulators; the accumulate always sees the pre-edge
    // window, so a simultaneous window load takes effect one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                win_reg[i] <= LOG_ZERO;
                acc_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (bus.load_win_reg)     win_reg[i] <= bus.win_log[i];
                if (bus.load_acc_sum_reg) acc_reg[i] <= acc_next_c[i];
            end
        end
    end

`ifdef NCC_PE_OVF_FLAG_EN
    logic [NUM_LANES-1:0] ovf_reg;

    // Sticky saturation flags, raised only by an accumulate that clamps
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= '0;
        end else if (bus.load_acc_sum_reg) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (clamp_c[i]) ovf_reg[i] <= 1'b1;
            end
        end
    end

    assign bus.acc_ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_ncc_pe.sv
// -----------------------------------------------------------------------------
// tb_ncc_pe
// Directed bench for ncc_pe with a lane-level arithmetic model and per-cycle
// comparison of every lane, plus hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_ncc_pe;
    import ncc_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ncc_pe_if bus ();

    ncc_pe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Model state: accumulator value, window pixel log magnitude and zero flag
    int     m_acc [NUM_LANES];
    bit     m_wz  [NUM_LANES];
    longint m_wm  [NUM_LANES];
    bit     m_ovf [NUM_LANES];

    // Linear-domain product of two log2 operands
    function automatic void model_prod(input log_t d, input bit wz, input longint wm,
                                       output int p, output bit sat);
        longint s, n, f;
        p   = 0;
        sat = 1'b0;
        if (d.zero || wz) return;
        s = longint'(d.mag) + wm;
        n = s >> 27;
        f = s & ((longint'(1) << 27) - 1);
        if (n >= 8) begin
            p   = 255;
            sat = 1'b1;
        end else begin
            p = int'((((longint'(1) << 27) + f) << n) >> 27);
        end
    endfunction

    // Reference model advancing on each rising edge
    always @(posedge clk) begin : model
        int p;
        bit s;
        int t;
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                m_acc[i] = 0;
                m_wz[i]  = 1'b1;
                m_wm[i]  = 0;
                m_ovf[i] = 1'b0;
            end
        end else begin
            if (bus.load_acc_sum_reg) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    model_prod(bus.desc_log[i], m_wz[i], m_wm[i], p, s);
                    t = m_acc[i] + p;
                    if (t > 255) begin
                        t = 255;
                        s = 1'b1;
                    end
                    m_acc[i] = t;
                    if (s) m_ovf[i] = 1'b1;
                end
            end
            if (bus.load_win_reg) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    m_wz[i] = bus.win_log[i].zero;
                    m_wm[i] = longint'(bus.win_log[i].mag);
                end
            end
        end
    end

    // Every-cycle comparison of all lanes against the model
    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                acc_t exp_acc;
                exp_acc = acc_t'(m_acc[i]);
                total++;
                if (bus.acc_out[i] !== exp_acc) begin
                    bad++;
                    $display("FAIL model_acc lane%0d t=%0t got=%0d exp=%0d",
                             i, $time, bus.acc_out[i], exp_acc);
                end
`ifdef NCC_PE_OVF_FLAG_EN
                total++;
                if (bus.acc_ovf[i] !== m_ovf[i]) begin
                    bad++;
                    $display("FAIL model_ovf lane%0d t=%0t got=%0b exp=%0b",
                             i, $time, bus.acc_ovf[i], m_ovf[i]);
                end
`endif
            end
        end
    end

    task automatic check_lit(input string nm, input int lane, input int exp_v);
        total++;
        if (int'(bus.acc_out[lane]) != exp_v) begin
            bad++;
            $display("FAIL %s lane%0d got=%0d exp=%0d", nm, lane, bus.acc_out[lane], exp_v);
        end
    endtask

    task automatic check_log(input string nm, input log_t got, input log_t exp_v);
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp_v);
        end
    endtask

    // Drive strobes for one cycle; called and returns on a falling edge
    task automatic step(input bit acc, input bit win);
        bus.load_acc_sum_reg = acc;
        bus.load_win_reg     = win;
        @(negedge clk);
        bus.load_acc_sum_reg = 1'b0;
        bus.load_win_reg     = 1'b0;
    endtask

    task automatic set_all(input int dpix, input int wpix);
        for (int i = 0; i < NUM_LANES; i++) begin
            bus.desc_log[i] = mitchell_log2(PIX_W'(dpix));
            bus.win_log[i]  = mitchell_log2(PIX_W'(wpix));
        end
    endtask

    initial begin
        rst                  = 1'b1;
        bus.load_acc_sum_reg = 1'b0;
        bus.load_win_reg     = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            bus.desc_log[i] = mitchell_log2(PIX_W'($urandom_range(1, 255)));
            bus.win_log[i]  = mitchell_log2(PIX_W'($urandom_range(1, 255)));
        end
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        check_en = 1'b1;

        // Operand encoding pins: 3 -> 1.5, 5 -> 2.25, 0 -> zero flag
        check_log("log2_of_3", mitchell_log2(8'd3), '{zero: 1'b0, mag: 32'h0C00_0000});
        check_log("log2_of_5", mitchell_log2(8'd5), '{zero: 1'b0, mag: 32'h1200_0000});
        check_log("log2_of_0", mitchell_log2(8'd0), LOG_ZERO);

        // Accumulate against the reset window (all zero flags) -> stays 0
        step(1'b1, 1'b0);
        for (int i = 0; i < NUM_LANES; i++) check_lit("reset_window", i, 0);

        // desc = i, window = i+1 (lane 15 both zero)
        for (int i = 0; i < NUM_LANES; i++) begin
            bus.desc_log[i] = mitchell_log2(PIX_W'(i < 15 ? i : 0));
            bus.win_log[i]  = mitchell_log2(PIX_W'(i < 15 ? i + 1 : 0));
        end
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        check_lit("ramp1", 0, 0);
        check_lit("ramp1", 1, 2);
        check_lit("ramp1", 3, 12);
        check_lit("ramp1", 4, 20);
        check_lit("ramp1", 14, 208);
        check_lit("ramp1", 15, 0);

        // Second accumulate: lane 14 saturates at 255
        step(1'b1, 1'b0);
        check_lit("ramp2", 1, 4);
        check_lit("ramp2", 3, 24);
        check_lit("ramp2", 4, 40);
        check_lit("ramp2", 14, 255);

        // Maximum operands: product saturation, then accumulator sticks
        set_all(255, 255);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        check_lit("max1", 0, 255);
        check_lit("max1", 15, 255);
        step(1'b1, 1'b0);
        check_lit("max2", 7, 255);
`ifdef NCC_PE_OVF_FLAG_EN
        total++;
        if (bus.acc_ovf !== '1) begin
            bad++;
            $display("FAIL ovf_all got=%h exp=%h", bus.acc_ovf, {NUM_LANES{1'b1}});
        end
`endif

        // Simultaneous window load and accumulate uses the old window
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_all(3, 4);
        step(1'b0, 1'b1);
        set_all(3, 8);
        step(1'b1, 1'b1);
        check_lit("overlap_old_win", 0, 12);
        check_lit("overlap_old_win", 9, 12);
        step(1'b1, 1'b0);
        check_lit("overlap_new_win", 0, 36);
        check_lit("overlap_new_win", 15, 36);

        // Reset wins over both strobes and clears the window bank
        set_all(3, 8);
        rst                  = 1'b1;
        bus.load_acc_sum_reg = 1'b1;
        bus.load_win_reg     = 1'b1;
        @(negedge clk);
        rst                  = 1'b0;
        bus.load_acc_sum_reg = 1'b0;
        bus.load_win_reg     = 1'b0;
        check_lit("rst_priority", 0, 0);
        check_lit("rst_priority", 12, 0);
        step(1'b1, 1'b0);
        check_lit("rst_win_zero", 5, 0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        check_lit("after_rst_load", 5, 24);

        // Mixed traffic checked by the per-cycle model comparison
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                bus.desc_log[i] = mitchell_log2(PIX_W'(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40)));
                bus.win_log[i]  = mitchell_log2(PIX_W'(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12)));
            end
            rst = (c == 20);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rst = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
